// File: rtl/rv32_mem_pkg.sv
// Shared types and limits for the RV32 memory responder: FSM states, error causes
// and the wait-state ceiling that sizes the wait counter.
package rv32_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    typedef enum logic [1:0] {
        NONE          = 2'd0,
        MISALIGNED    = 2'd1,
        OUT_OF_RANGE  = 2'd2,
        WRITE_PROTECT = 2'd3
    } mem_err_cause_t;

    localparam int unsigned MEM_MAX_WAIT_STATES = 15;
    localparam int unsigned MEM_WAIT_CNT_W      = $clog2(MEM_MAX_WAIT_STATES + 1);

endpackage

// File: rtl/rv32_mod_mem_responder_if.sv
// Request/response bus between an initiator (master) and the memory responder (slave).
interface rv32_mod_mem_responder_if;

    logic        req;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic        ack;
    logic        err;
    logic [31:0] data_o;

    modport master (
        output req, wr, be, addr, data_i,
        input  ack, err, data_o
    );

    modport slave (
        input  req, wr, be, addr, data_i,
        output ack, err, data_o
    );

endinterface

// File: rtl/rv32_mod_mem_sram_array.sv
// Single-port word array: synchronous read, per-byte write enables, no reset on contents.
module rv32_mod_mem_sram_array #(
    parameter  int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Read-first: a write cycle returns the old word, which the responder never uses.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/rv32_mod_mem_responder.sv
// Memory responder: req/ack/err handshake, WAIT_STATES programmable latency, byte writes.
// Define RV32_MEM_RESP_WRITE_PROTECT_EN to make the first RO_WORDS words write-protected.
module rv32_mod_mem_responder
    import rv32_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned RO_WORDS    = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    rv32_mod_mem_responder_if.slave  bus
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
    localparam logic [MEM_WAIT_CNT_W-1:0] LAST_WAIT =
        (WAIT_STATES > 0) ? MEM_WAIT_CNT_W'(WAIT_STATES - 1) : '0;

`ifdef RV32_MEM_RESP_WRITE_PROTECT_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    mem_resp_state_t            state_q;
    logic [MEM_WAIT_CNT_W-1:0]  cnt_q;
    logic                       ack_q;
    logic                       err_q;
    logic                       rd_vld_q;

    logic                       wr_q;
    logic [3:0]                 be_q;
    logic [AW-1:0]              idx_q;
    logic [31:0]                wdata_q;
    mem_err_cause_t             cause_q;

    logic [AW-1:0]              idx_in;
    logic                       in_range;
    logic                       wp_hit;
    mem_err_cause_t             cause_in;
    logic                       accept;
    mem_err_cause_t             resp_cause;
    logic                       resp_wr;

    logic                       sram_we;
    logic [AW-1:0]              sram_addr;
    logic [31:0]                sram_rdata;

    // Decode of the live request; 33-bit compares so the range cannot wrap past 2^32.
    assign idx_in   = AW'((bus.addr - BASE_ADDR) >> 2);
    assign in_range = ({1'b0, bus.addr} >= {1'b0, BASE_ADDR}) && ({1'b0, bus.addr} < LIMIT);
    assign wp_hit   = WP_EN && bus.wr && (32'(idx_in) < RO_WORDS);

    always_comb begin
        cause_in = NONE;
        if (bus.addr[1:0] != 2'b00) begin
            cause_in = MISALIGNED;
        end else if (!in_range) begin
            cause_in = OUT_OF_RANGE;
        end else if (wp_hit) begin
            cause_in = WRITE_PROTECT;
        end
    end

    assign accept = (state_q == IDLE) && bus.req;

    // With zero wait states RESP is entered straight from IDLE, so use the live decode.
    assign resp_cause = (state_q == IDLE) ? cause_in : cause_q;
    assign resp_wr    = (state_q == IDLE) ? bus.wr   : wr_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= bus.wr;
            be_q    <= bus.be;
            idx_q   <= idx_in;
            wdata_q <= bus.data_i;
            cause_q <= cause_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_vld_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (bus.req) begin
                        if (WAIT_STATES == 0) begin
                            state_q  <= RESP;
                            ack_q    <= (resp_cause == NONE);
                            err_q    <= (resp_cause != NONE);
                            rd_vld_q <= (resp_cause == NONE) && !resp_wr;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.req) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == LAST_WAIT) begin
                        state_q  <= RESP;
                        cnt_q    <= '0;
                        ack_q    <= (resp_cause == NONE);
                        err_q    <= (resp_cause != NONE);
                        rd_vld_q <= (resp_cause == NONE) && !resp_wr;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // The write lands on the edge closing RESP, so a reset during the transaction drops it.
    assign sram_we   = (state_q == RESP) && ack_q && wr_q;
    assign sram_addr = (state_q == IDLE) ? idx_in : idx_q;

    rv32_mod_mem_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk     (clk),
        .we_i    (sram_we),
        .be_i    (be_q),
        .addr_i  (sram_addr),
        .wdata_i (wdata_q),
        .rdata_o (sram_rdata)
    );

    assign bus.ack    = ack_q;
    assign bus.err    = err_q;
    assign bus.data_o = rd_vld_q ? sram_rdata : '0;

endmodule

// File: tb/tb_rv32_mod_mem_responder.sv
// Directed bench for rv32_mod_mem_responder: three instances (0 and 3 wait states, and a
// RO_WORDS=4 instance whose expectations follow RV32_MEM_RESP_WRITE_PROTECT_EN).
module tb_rv32_mod_mem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        int          d;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n  [3];
    logic        req_a  [3];
    logic        wr_a   [3];
    logic [3:0]  be_a   [3];
    logic [31:0] addr_a [3];
    logic [31:0] wd_a   [3];
    logic        ack_a  [3];
    logic        err_a  [3];
    logic [31:0] rd_a   [3];

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rv32_mod_mem_responder_if bus_if ();
        assign bus_if.req    = req_a[g];
        assign bus_if.wr     = wr_a[g];
        assign bus_if.be     = be_a[g];
        assign bus_if.addr   = addr_a[g];
        assign bus_if.data_i = wd_a[g];
        assign ack_a[g]      = bus_if.ack;
        assign err_a[g]      = bus_if.err;
        assign rd_a[g]       = bus_if.data_o;

        rv32_mod_mem_responder #(
            .BASE_ADDR   (BASE),
            .DEPTH_WORDS (DEPTH),
            .WAIT_STATES ((g == 1) ? 3 : 0),
            .RO_WORDS    ((g == 2) ? 4 : 0)
        ) u_dut (
            .clk   (clk),
            .reset (rst_n[g]),
            .bus   (bus_if)
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input int d, input logic wr, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, input logic ea, input logic ee, input logic [31:0] er);
        vec_t v;
        v.d = d; v.wr = wr; v.be = be; v.addr = addr; v.wdata = wd;
        v.exp_ack = ea; v.exp_err = ee; v.exp_rd = er;
        vecs.push_back(v);
    endtask

    // One transaction; lat counts cycles from the accepting edge to the edge sampling ack/err.
    task automatic xact(input int d, input logic wr, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output logic ack, output logic err,
                        output logic [31:0] rd);
        @(negedge clk);
        req_a[d] = 1'b1; wr_a[d] = wr; be_a[d] = be; addr_a[d] = addr; wd_a[d] = wd;
        lat = -1; ack = 1'b0; err = 1'b0; rd = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ack_a[d] || err_a[d]) begin
                lat = k; ack = ack_a[d]; err = err_a[d]; rd = rd_a[d];
                break;
            end
        end
        req_a[d] = 1'b0;
        @(negedge clk);
    endtask

    task automatic quiet(input int d, input int n, output logic seen);
        seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (ack_a[d] || err_a[d]) seen = 1'b1;
        end
    endtask

    // Two reads with req held high throughout; addr switches during the first ack cycle.
    task automatic b2b(input int d, input logic [31:0] a1, input logic [31:0] a2,
                       output int k1, output int k2, output logic [31:0] r1,
                       output logic [31:0] r2, output logic stray);
        @(negedge clk);
        req_a[d] = 1'b1; wr_a[d] = 1'b0; be_a[d] = 4'h0; addr_a[d] = a1;
        k1 = -1; k2 = -1; r1 = '0; r2 = '0; stray = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ack_a[d]) begin
                if (k1 < 0) begin
                    k1 = k; r1 = rd_a[d]; addr_a[d] = a2;
                end else begin
                    k2 = k; r2 = rd_a[d];
                    break;
                end
            end else if (err_a[d] || rd_a[d] != 32'h0) begin
                stray = 1'b1;
            end
        end
        req_a[d] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        logic        ack;
        logic        err;
        logic        seen;
        logic [31:0] rd;
        logic [31:0] v0;
        int          k1;
        int          k2;
        logic [31:0] r1;
        logic [31:0] r2;

        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; req_a[d] = 1'b0; wr_a[d] = 1'b0;
            be_a[d] = 4'h0; addr_a[d] = '0; wd_a[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst%0d_ackerr", d), 32'({ack_a[d], err_a[d]}), 32'h0);
            chk($sformatf("rst%0d_data", d), rd_a[d], 32'h0);
            rst_n[d] = 1'b1;
        end
        @(negedge clk);

        // Instance 0: no wait states
        add(0, 1, 4'hF, BASE,        32'hDEADBEEF, 1, 0, 32'h0);
        add(0, 0, 4'h0, BASE,        32'h0,        1, 0, 32'hDEADBEEF);
        add(0, 1, 4'hF, BASE + 4,    32'h11223344, 1, 0, 32'h0);
        add(0, 1, 4'h2, BASE + 4,    32'h0000AB00, 1, 0, 32'h0);
        add(0, 0, 4'h0, BASE + 4,    32'h0,        1, 0, 32'h1122AB44);
        add(0, 0, 4'h0, BASE + 2,    32'h0,        0, 1, 32'h0);
        add(0, 0, 4'h0, BASE + 64,   32'h0,        0, 1, 32'h0);
        add(0, 0, 4'h0, BASE + 4,    32'h0,        1, 0, 32'h1122AB44);
        add(0, 1, 4'hF, BASE + 60,   32'hCAFEF00D, 1, 0, 32'h0);
        add(0, 0, 4'h0, BASE + 60,   32'h0,        1, 0, 32'hCAFEF00D);
        add(0, 1, 4'hF, BASE - 4,    32'h0BADF00D, 0, 1, 32'h0);
        add(0, 1, 4'hF, 32'hFFFFFFFC, 32'h0BADF00D, 0, 1, 32'h0);
        add(0, 1, 4'h0, BASE,        32'hFFFFFFFF, 1, 0, 32'h0);
        add(0, 0, 4'h0, BASE,        32'h0,        1, 0, 32'hDEADBEEF);
        add(0, 1, 4'hF, BASE + 6,    32'hFFFFFFFF, 0, 1, 32'h0);
        add(0, 0, 4'h0, BASE + 4,    32'h0,        1, 0, 32'h1122AB44);
        // Instance 1: three wait states
        add(1, 1, 4'hF, BASE,        32'h01020304, 1, 0, 32'h0);
        add(1, 1, 4'hF, BASE + 12,   32'h55AA55AA, 1, 0, 32'h0);
        add(1, 0, 4'h0, BASE + 12,   32'h0,        1, 0, 32'h55AA55AA);
        add(1, 0, 4'h0, BASE + 3,    32'h0,        0, 1, 32'h0);
        add(1, 0, 4'h0, BASE + 64,   32'h0,        0, 1, 32'h0);
        // Instance 2: word 4 lies above the RO_WORDS window in every build
        add(2, 1, 4'hF, BASE + 16,   32'h12345678, 1, 0, 32'h0);
        add(2, 0, 4'h0, BASE + 16,   32'h0,        1, 0, 32'h12345678);

        foreach (vecs[i]) begin
            xact(vecs[i].d, vecs[i].wr, vecs[i].be, vecs[i].addr, vecs[i].wdata, lat, ack, err, rd);
            chk($sformatf("v%0d_lat", i), 32'(lat), (vecs[i].d == 1) ? 32'd4 : 32'd1);
            chk($sformatf("v%0d_ackerr", i), 32'({ack, err}), 32'({vecs[i].exp_ack, vecs[i].exp_err}));
            chk($sformatf("v%0d_data", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_idle_data", i), rd_a[vecs[i].d], 32'h0);
        end

        b2b(0, BASE, BASE + 60, k1, k2, r1, r2, seen);
        chk("b2b0_k1", 32'(k1), 32'd1);
        chk("b2b0_k2", 32'(k2), 32'd3);
        chk("b2b0_r1", r1, 32'hDEADBEEF);
        chk("b2b0_r2", r2, 32'hCAFEF00D);
        chk("b2b0_stray", 32'(seen), 32'h0);

        b2b(1, BASE, BASE + 12, k1, k2, r1, r2, seen);
        chk("b2b1_k1", 32'(k1), 32'd4);
        chk("b2b1_k2", 32'(k2), 32'd9);
        chk("b2b1_r1", r1, 32'h01020304);
        chk("b2b1_r2", r2, 32'h55AA55AA);
        chk("b2b1_stray", 32'(seen), 32'h0);

        // Write abandoned after one cycle of req
        @(negedge clk);
        req_a[1] = 1'b1; wr_a[1] = 1'b1; be_a[1] = 4'hF; addr_a[1] = BASE; wd_a[1] = 32'hFFFFFFFF;
        @(negedge clk);
        req_a[1] = 1'b0;
        quiet(1, 10, seen);
        chk("drop_no_resp", 32'(seen), 32'h0);
        xact(1, 0, 4'h0, BASE, 32'h0, lat, ack, err, rd);
        chk("drop_after_lat", 32'(lat), 32'd4);
        chk("drop_after_data", rd, 32'h01020304);

        // Reset pulsed while a write is waiting
        @(negedge clk);
        req_a[1] = 1'b1; wr_a[1] = 1'b1; be_a[1] = 4'hF; addr_a[1] = BASE + 12; wd_a[1] = 32'h0;
        repeat (3) @(negedge clk);
        rst_n[1] = 1'b0;
        req_a[1] = 1'b0;
        #1;
        chk("midrst_ackerr", 32'({ack_a[1], err_a[1]}), 32'h0);
        chk("midrst_data", rd_a[1], 32'h0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        quiet(1, 8, seen);
        chk("midrst_no_resp", 32'(seen), 32'h0);
        xact(1, 0, 4'h0, BASE + 12, 32'h0, lat, ack, err, rd);
        chk("midrst_after_lat", 32'(lat), 32'd4);
        chk("midrst_after_ackerr", 32'({ack, err}), 32'b10);
        chk("midrst_after_data", rd, 32'h55AA55AA);

        // Write into the RO_WORDS window (word 2)
        xact(2, 0, 4'h0, BASE + 8, 32'h0, lat, ack, err, v0);
        chk("wp_pre_rd_ackerr", 32'({ack, err}), 32'b10);
        xact(2, 1, 4'hF, BASE + 8, 32'hAAAA5555, lat, ack, err, rd);
`ifdef RV32_MEM_RESP_WRITE_PROTECT_EN
        chk("wp_wr_ackerr", 32'({ack, err}), 32'b01);
        xact(2, 0, 4'h0, BASE + 8, 32'h0, lat, ack, err, rd);
        chk("wp_post_rd_ackerr", 32'({ack, err}), 32'b10);
        chk("wp_post_rd_data", rd, v0);
`else
        chk("wp_wr_ackerr", 32'({ack, err}), 32'b10);
        xact(2, 0, 4'h0, BASE + 8, 32'h0, lat, ack, err, rd);
        chk("wp_post_rd_ackerr", 32'({ack, err}), 32'b10);
        chk("wp_post_rd_data", rd, 32'hAAAA5555);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/rv32_mod_mem_responder.md
RV32_MOD_MEM_RESPONDER -- requirements
Module: rv32_mod_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h80000000: byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words, a power of two, at least 4.
REQ-003 SHALL have parameter WAIT_STATES, default 0, range 0..15: extra cycles inserted before the response.
REQ-004 SHALL have parameter RO_WORDS, default 0: number of write-protected words starting at word 0.
REQ-005 clk  input  1: single clock; all state changes on its rising edge.
REQ-006 reset  input  1: asynchronous, active-low reset; the block is in reset while reset==0.
REQ-007 req  input  1: request from the initiator; held high until ack or err.
REQ-008 wr  input  1: 1 = write, 0 = read.
REQ-009 be  input  4: byte enables for a write; ignored on a read.
REQ-010 addr  input  32: byte address.
REQ-011 data_i  input  32: write data.
REQ-012 ack  output  1: one-cycle pulse marking successful completion.
REQ-013 err  output  1: one-cycle pulse marking failed completion; never high together with ack.
REQ-014 data_o  output  32: read data.

Function
REQ-015 SHALL implement the states IDLE, WAIT, RESP; the state type comes from the shared package.
REQ-016 IDLE: when req==1 is sampled, SHALL capture wr, be, addr and data_i, then go to WAIT if WAIT_STATES>0, else to RESP.
REQ-017 WAIT: SHALL count WAIT_STATES cycles, then go to RESP. Input changes while pending SHALL be ignored.
REQ-018 Latency: ack/err SHALL be high exactly WAIT_STATES+1 cycles after the edge at which req was accepted.
REQ-019 RESP: SHALL assert exactly one of ack or err for one cycle, then return to IDLE.
REQ-020 Back-to-back: req still high in the cycle after RESP SHALL be accepted as a new request. Throughput is one transaction per WAIT_STATES+2 cycles.
REQ-021 err SHALL be raised when addr[1:0]!=0 or addr is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS). Address arithmetic is unsigned 33-bit with no wrap-around, so the top-of-range address BASE+4*DEPTH-4 is valid.
REQ-022 Write: bytes with be[i]==1 SHALL be committed at the RESP edge only. be==4'b0000 SHALL ack with no memory change.
REQ-023 Read: data_o SHALL carry the word during the ack cycle and be 0 in every other cycle, including err cycles.
REQ-024 If req falls before RESP, the transaction SHALL be abandoned: no ack, no err, no write, return to IDLE.
REQ-025 A read following a write to the same word SHALL return the newly written data (no stale forwarding hazard).

Reset
REQ-026 While reset==0: state=IDLE, wait counter=0, ack=0, err=0, data_o=0.
REQ-027 Reset asserted mid-transaction SHALL discard that transaction without committing its write.
REQ-028 Memory contents are not cleared by reset.

Configuration
REQ-029 With macro RV32_MEM_RESP_WRITE_PROTECT_EN defined, a valid-address write to a word index below RO_WORDS SHALL return err and leave memory unchanged; reads there are unaffected.
REQ-030 Without the macro, all words are writable and RO_WORDS has no effect.

Structure
REQ-031 Package rv32_mem_pkg SHALL hold:
- the state enum mem_resp_state_t (IDLE, WAIT, RESP);
- the error-cause enum (NONE, MISALIGNED, OUT_OF_RANGE, WRITE_PROTECT);
- the WAIT_STATES maximum constant.
REQ-032 The storage SHALL be sub-module rv32_mod_mem_sram_array: single-port, synchronous-read, byte-enabled write, no reset.
REQ-033 FSM, counter, address decode and protection check SHALL live in the top module.

Verification
REQ-034 WAIT_STATES=0: write 32'hDEADBEEF, be=4'hF, to BASE; then read BASE -> ack one cycle after each accept, read data_o=32'hDEADBEEF.
REQ-035 be=4'b0010 write of 32'h0000AB00 over 32'h11223344 -> subsequent read returns 32'h1122AB44.
REQ-036 Read of BASE+2, then read of BASE+4*DEPTH_WORDS -> err each time, ack=0, data_o=0, memory unchanged.
REQ-037 WAIT_STATES=3: req held through two back-to-back reads -> ack at cycles 4 and 9 after the first accept.
REQ-038 WAIT_STATES=3: req dropped after 1 cycle on a write, and separately reset pulsed mid-write -> no ack/err, word unchanged, next request served normally.
REQ-039 With RV32_MEM_RESP_WRITE_PROTECT_EN and RO_WORDS=4: write to BASE+8 -> err and data unchanged; write to BASE+16 -> ack.
